// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx: 8N1 UART receiver with 16x oversampling.
// Delivers each correctly framed byte as a one-clock ascii_ready strobe.
module uart_ascii_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] ascii,
  output logic       ascii_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running divider; frames never re-phase it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      ascii         <= 8'h00;
      ascii_ready   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      ascii_ready   <= 1'b0;
      framing_error <= 1'b0;
      if (tick) begin
        if (rx_s) armed <= 1'b1;
        unique case (state)
          IDLE: begin
            if (armed && !rx_s) begin
              tick_cnt <= '0;
              state    <= START;
            end
          end
          START: begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          DATA: begin
            if (tick_cnt == 4'd15) begin
              tick_cnt       <= '0;
              shift[bit_idx] <= rx_s;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          STOP: begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) begin
                ascii       <= shift;
                ascii_ready <= 1'b1;
              end else begin
                framing_error <= 1'b1;
                armed         <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  a_excl: assert property (
    @(posedge clk) disable iff (!reset) !(ascii_ready && framing_error)
  );

endmodule

// File: tb/tb_uart_ascii_rx.sv
// tb_uart_ascii_rx: directed frames with a queue-based strobe scoreboard.
// Divider is shrunk (DIV=10, 160 clk/bit) to keep runtime short.
module tb_uart_ascii_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] ascii;
  logic       ascii_ready;
  logic       framing_error;
  logic       busy;

  typedef struct packed {
    logic       fe;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         busy_cnt = 0;
  logic [7:0] prev_ascii = 8'h00;

  uart_ascii_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .ascii(ascii),
    .ascii_ready(ascii_ready),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act,
                             input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    rx = stop;
    wait_clks(BIT);
  endtask

  task automatic push(input logic fe, input logic [7:0] d);
    exp_t e;
    e.fe   = fe;
    e.data = d;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per strobe, and polices ascii holding.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_ascii = 8'h00;
    end else begin
      if (busy) busy_cnt++;
      if (ascii_ready && framing_error)
        check("strobe_overlap", 1, 0);
      if (ascii_ready || framing_error) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got ready=%0b fe=%0b ascii=%0h required none",
                   ascii_ready, framing_error, ascii);
        end else begin
          e = q.pop_front();
          check("strobe_kind_fe", {31'd0, framing_error}, {31'd0, e.fe});
          check("ascii_value", {24'd0, ascii}, {24'd0, e.data});
        end
      end else if (ascii !== prev_ascii) begin
        check("ascii_hold", {24'd0, ascii}, {24'd0, prev_ascii});
      end
      prev_ascii = ascii;
    end
  end

  initial begin
    wait_clks(5);
    check("rst_ascii", {24'd0, ascii}, 32'h0);
    check("rst_ready", {31'd0, ascii_ready}, 32'h0);
    check("rst_fe", {31'd0, framing_error}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    wait_clks(2 * BIT);

    // Single frame; busy spans 152 ticks = 1520 clk.
    busy_cnt = 0;
    push(1'b0, 8'h41);
    send(8'h41, 1'b1);
    wait_clks(BIT);
    check_range("busy_len_0x41", busy_cnt, 1510, 1530);

    // Back-to-back frames.
    push(1'b0, 8'h48);
    push(1'b0, 8'h69);
    send(8'h48, 1'b1);
    send(8'h69, 1'b1);
    wait_clks(BIT);

    // Short glitch must not start a frame.
    rx = 1'b0;
    wait_clks(46);
    rx = 1'b1;
    wait_clks(BIT);
    check("glitch_busy", {31'd0, busy}, 32'h0);

    // Bad stop bit: framing error, ascii keeps 0x69.
    push(1'b1, 8'h69);
    send(8'h55, 1'b0);
    rx = 1'b1;
    wait_clks(3 * BIT);

    // Line held low across reset release.
    rx = 1'b0;
    reset = 1'b0;
    wait_clks(5);
    check("rst2_ascii", {24'd0, ascii}, 32'h0);
    check("rst2_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    wait_clks(5 * BIT);
    check("low_hold_busy", {31'd0, busy}, 32'h0);
    rx = 1'b1;
    wait_clks(2 * BIT);
    push(1'b0, 8'h7A);
    send(8'h7A, 1'b1);
    wait_clks(BIT);

    // Reset mid data bit 4 of 0x33 aborts the frame.
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h33 >> i) & 8'h01;
      wait_clks(BIT);
    end
    rx = 1'b1;
    wait_clks(BIT / 2);
    check("pre_abort_busy", {31'd0, busy}, 32'h1);
    reset = 1'b0;
    wait_clks(4);
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_ascii", {24'd0, ascii}, 32'h0);
    reset = 1'b1;
    wait_clks(2 * BIT);
    push(1'b0, 8'h31);
    send(8'h31, 1'b1);

    // Extreme byte values pass unfiltered.
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);

    for (int t = 0; t < 4 * BIT && q.size() != 0; t++) wait_clks(1);
    check("queue_drained", q.size(), 0);
    wait_clks(BIT);
    check("final_busy", {31'd0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_ascii_rx.md
UART_ASCII_RX -- requirements
Module: uart_ascii_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port ascii  output  8  last correctly received character; feeds the character buffer's ascii input.
REQ-007 SHALL have port ascii_ready  output  1  one-clock strobe, ascii valid; feeds the character buffer's ready input.
REQ-008 SHALL have port framing_error  output  1  one-clock strobe on bad stop bit.
REQ-009 SHALL have port busy  output  1  high while a frame is being received (any state except IDLE).

Function
REQ-010 SHALL synchronise rx through two flip-flops before any use; the synchronised signal is rx_s, and synchronisation latency is 2 clk.
REQ-011 SHALL generate a 16x oversample tick from a counter that counts 0..DIV-1, where DIV = CLK_FREQ/(BAUD*16) with integer truncation (651 at defaults).
REQ-012 SHALL assert the tick for one clk when the counter wraps; the counter SHALL free-run and SHALL NOT be re-phased by frame events.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, plus one-bit flag armed.
REQ-014 SHALL clear armed on reset and set it on the first tick at which rx_s=1, so that a line held low at reset release is not taken as a start bit.
REQ-015 IDLE: on a tick with armed=1 and rx_s=0 SHALL clear the tick count (0..15) and go to START.
REQ-016 START: SHALL re-sample rx_s on the 8th tick (mid-bit); if rx_s=0, go to DATA with the tick count and bit index cleared; if rx_s=1, treat as a glitch and return to IDLE with no strobe.
REQ-017 DATA: SHALL sample rx_s every 16th tick into shift-register bit (bit index), LSB first; after bit index 7 is sampled, go to STOP.
REQ-018 STOP: SHALL sample rx_s on the 16th tick.
REQ-019 STOP with rx_s=1: SHALL load ascii with the shifted byte, pulse ascii_ready for exactly 1 clk, and return to IDLE.
REQ-020 STOP with rx_s=0: SHALL pulse framing_error for 1 clk, leave ascii unchanged, not assert ascii_ready, clear armed, and return to IDLE.
REQ-021 ascii SHALL hold its value between strobes and change only in the same cycle as the ascii_ready strobe.
REQ-022 ascii_ready and framing_error SHALL never be asserted in the same cycle.
REQ-023 Either strobe SHALL be followed by at least one tick in IDLE before the next frame is accepted.
REQ-024 Latency from the mid-stop-bit sample tick to the ascii_ready rising edge SHALL be 1 clk.
REQ-025 A new start edge during STOP before its sample SHALL be ignored; after return to IDLE it SHALL be detected normally.
REQ-026 Byte value is passed unfiltered: 0x00..0xFF are all delivered; the consumer decides printability.

Reset
REQ-027 While reset=0: ascii=8'h00, ascii_ready=0, framing_error=0, busy=0, state=IDLE, armed=0, and the divider, tick, bit-index and shift registers are cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no strobe.
REQ-029 After reset release the partial frame SHALL be discarded.
REQ-030 After reset release, reception SHALL resume only after armed is set.

Verification
REQ-031 Defaults, rx idle high, send 8N1 frame 0x41 at 10416 clk/bit -> exactly one ascii_ready pulse, ascii=0x41, framing_error never high, busy high for about 9.5 bit times.
REQ-032 Back-to-back frames 0x48, 0x69 with no idle gap beyond the stop bit -> two ascii_ready pulses, values 0x48 then 0x69 in order.
REQ-033 rx low pulse of 3000 clk, then high -> no strobe, busy returns low, FSM back in IDLE within 1 bit time.
REQ-034 Frame 0x55 with stop bit driven low, then rx high -> one framing_error pulse, no ascii_ready, ascii keeps its prior value.
REQ-035 Hold rx=0 through reset release for 5 bit times, then rx=1 for 2 bit times, then send 0x7A -> no strobe during the low period; one ascii_ready with ascii=0x7A.
REQ-036 Assert reset during data bit 4 of frame 0x33, release, then send 0x31 -> no strobe for the aborted frame; ascii=0x31 with a single ascii_ready.
